// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-bus responder: access masks, FSM states,
// size normalisation and byte-mask expansion.
package data_memory_responder_pkg;

    localparam logic [3:0] MEMSIZE_B = 4'b0001;
    localparam logic [3:0] MEMSIZE_H = 4'b0011;
    localparam logic [3:0] MEMSIZE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Unsupported mask encodings behave as full-word accesses.
    function automatic logic [3:0] norm_size(input logic [3:0] size);
        logic [3:0] res;
        res = MEMSIZE_W;
        if (size == MEMSIZE_B || size == MEMSIZE_H) begin
            res = size;
        end
        return res;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] res;
        res = '0;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = {8{mask[b]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port word RAM with per-byte write enables and registered read data.
// Read data only updates on an enabled read, so it holds between loads.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-bus responder: decodes byte-lane-masked loads/stores into a local RAM and
// returns zero-extended load data after a fixed latency.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned RSP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic [31:0] dbus_cmd_addr,
    input  logic [31:0] dbus_cmd_data,
    input  logic        dbus_cmd_we,
    input  logic [3:0]  dbus_cmd_size,
    input  logic        dbus_cmd_valid,
    output logic        dbus_cmd_ready,
    output logic [31:0] dbus_rsp_data,
    output logic        dbus_rsp_valid,
    output logic        dbus_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (RSP_LATENCY > 1) ? 4'(RSP_LATENCY - 2) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q;
    logic [3:0]  size_q;
    logic        zero_q;

    logic [31:0]   off_c;
    logic          in_range_c;
    logic [1:0]    lane_c;
    logic [AW-1:0] idx_c;
    logic [3:0]    size_n_c;
    logic [6:0]    mask_wide_c;
    logic          cross_c;
    logic          accept_c;
    logic          ld_acc_c;
    logic [31:0]   wdata_c;
    logic [31:0]   ram_rdata;

    // Address decode and lane-mask generation
    always_comb begin
        off_c       = dbus_cmd_addr - BASE_ADDR;
        in_range_c  = (dbus_cmd_addr >= BASE_ADDR) && ({1'b0, off_c} < LIMIT);
        lane_c      = off_c[1:0];
        idx_c       = off_c[AW+1:2];
        size_n_c    = norm_size(dbus_cmd_size);
        mask_wide_c = {3'b000, size_n_c} << lane_c;
        cross_c     = |mask_wide_c[6:4];
        accept_c    = dbus_cmd_valid & dbus_cmd_ready;
        ld_acc_c    = accept_c & ~dbus_cmd_we;
        wdata_c     = dbus_cmd_data << {lane_c, 3'b000};
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (accept_c & in_range_c),
        .we   (dbus_cmd_we),
        .be   (mask_wide_c[3:0]),
        .addr (idx_c),
        .wdata(wdata_c),
        .rdata(ram_rdata)
    );

    // Next-state logic; RESP accepts a new command exactly like IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (state_q == RESP) begin
                    state_d = IDLE;
                end
                if (ld_acc_c) begin
                    if (RSP_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            dbus_cmd_ready <= 1'b1;
            dbus_rsp_valid <= 1'b0;
            dbus_err       <= 1'b0;
            lane_q         <= 2'd0;
            size_q         <= MEMSIZE_W;
            zero_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dbus_cmd_ready <= (state_d != WAIT);
            dbus_rsp_valid <= (state_d == RESP);
            dbus_err       <= accept_c & (~in_range_c | cross_c);
            if (ld_acc_c) begin
                lane_q <= lane_c;
                size_q <= size_n_c;
                zero_q <= ~in_range_c;
            end
        end
    end

    // Response data is built from held load attributes so it stays stable between responses
    assign dbus_rsp_data = zero_q ? 32'h0
                         : ((ram_rdata >> {lane_q, 3'b000}) & expand_mask(size_q));

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: instance A (latency 1) and instance B (latency 3) share a clock;
// drivers push expected responses/errors, per-instance monitors pop and compare.
module tb_data_memory_responder;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0011;
    localparam logic [3:0] SZ_W = 4'b1111;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rstf_a, rstf_b;

    logic [31:0] a_addr, a_data, a_rdata;
    logic [3:0]  a_size;
    logic        a_we, a_valid, a_ready, a_rvalid, a_err;
    logic [31:0] b_addr, b_data, b_rdata;
    logic [3:0]  b_size;
    logic        b_we, b_valid, b_ready, b_rvalid, b_err;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_eq[$];
    int   b_eq[$];

    data_memory_responder #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RSP_LATENCY(1)
    ) u_dut_a (
        .clk(clk), .rstf(rstf_a),
        .dbus_cmd_addr(a_addr), .dbus_cmd_data(a_data), .dbus_cmd_we(a_we),
        .dbus_cmd_size(a_size), .dbus_cmd_valid(a_valid), .dbus_cmd_ready(a_ready),
        .dbus_rsp_data(a_rdata), .dbus_rsp_valid(a_rvalid), .dbus_err(a_err)
    );

    data_memory_responder #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RSP_LATENCY(3)
    ) u_dut_b (
        .clk(clk), .rstf(rstf_b),
        .dbus_cmd_addr(b_addr), .dbus_cmd_data(b_data), .dbus_cmd_we(b_we),
        .dbus_cmd_size(b_size), .dbus_cmd_valid(b_valid), .dbus_cmd_ready(b_ready),
        .dbus_rsp_data(b_rdata), .dbus_rsp_valid(b_rvalid), .dbus_err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Presents a command and waits (bounded) for acceptance; called just after a falling edge
    task automatic issue(input bit sel, input logic we, input logic [3:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_data, input bit exp_err,
                         input bit expect_rsp, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        if (sel) begin
            b_we = we; b_size = size; b_addr = addr; b_data = data; b_valid = 1'b1;
        end else begin
            a_we = we; a_size = size; a_addr = addr; a_data = data; a_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                acc_cyc = cyc;
                if (!we && expect_rsp) begin
                    if (sel) b_q.push_back('{exp_data, cyc + 3});
                    else     a_q.push_back('{exp_data, cyc + 1});
                end
                if (exp_err) begin
                    if (sel) b_eq.push_back(cyc + 1);
                    else     a_eq.push_back(cyc + 1);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) flag_fail(sel ? "b_accept_timeout" : "a_accept_timeout");
    endtask

    task automatic idle_bus();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Monitor for instance A
    always @(negedge clk) begin : mon_a
        exp_t e;
        bit   ee;
        if (rstf_a) begin
            if (a_rvalid === 1'b1) begin
                if (a_q.size() == 0) begin
                    flag_fail("a_unexpected_rsp");
                end else begin
                    e = a_q.pop_front();
                    chk("a_rsp_data", a_rdata, e.data);
                    chk("a_rsp_latency", 32'(cyc), 32'(e.due));
                end
            end else if (a_q.size() != 0 && cyc > a_q[0].due) begin
                chk("a_rsp_missing", 32'(cyc), 32'(a_q[0].due));
                void'(a_q.pop_front());
            end
            ee = (a_eq.size() != 0 && a_eq[0] == cyc);
            if (ee) void'(a_eq.pop_front());
            if (ee || a_err !== 1'b0) chk("a_err", {31'b0, a_err}, {31'b0, ee});
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin : mon_b
        exp_t e;
        bit   ee;
        if (rstf_b) begin
            if (b_rvalid === 1'b1) begin
                if (b_q.size() == 0) begin
                    flag_fail("b_unexpected_rsp");
                end else begin
                    e = b_q.pop_front();
                    chk("b_rsp_data", b_rdata, e.data);
                    chk("b_rsp_latency", 32'(cyc), 32'(e.due));
                end
            end else if (b_q.size() != 0 && cyc > b_q[0].due) begin
                chk("b_rsp_missing", 32'(cyc), 32'(b_q[0].due));
                void'(b_q.pop_front());
            end
            ee = (b_eq.size() != 0 && b_eq[0] == cyc);
            if (ee) void'(b_eq.pop_front());
            if (ee || b_err !== 1'b0) chk("b_err", {31'b0, b_err}, {31'b0, ee});
        end
    end

    initial begin
        int acc;
        int acc_prev;
        rstf_a = 1'b0; rstf_b = 1'b0;
        a_addr = '0; a_data = '0; a_we = 1'b0; a_size = SZ_W; a_valid = 1'b0;
        b_addr = '0; b_data = '0; b_we = 1'b0; b_size = SZ_W; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstf_a = 1'b1; rstf_b = 1'b1;
        @(negedge clk);

        chk("a_reset_ready", {31'b0, a_ready}, 32'd1);
        chk("a_reset_rvalid", {31'b0, a_rvalid}, 32'd0);
        chk("a_reset_rdata", a_rdata, 32'h0);
        chk("a_reset_err", {31'b0, a_err}, 32'd0);
        chk("b_reset_ready", {31'b0, b_ready}, 32'd1);
        chk("b_reset_rdata", b_rdata, 32'h0);

        // Latency 1: store then immediate load of the same word
        issue(0, 1'b1, SZ_W, 32'h10, 32'hCAFE_BABE, 32'h0, 0, 0, acc);
        issue(0, 1'b0, SZ_W, 32'h10, 32'h0, 32'hCAFE_BABE, 0, 1, acc);
        idle_bus();
        repeat (2) @(negedge clk);

        // Byte lanes, crossing and sizes on the latency-3 instance
        issue(1, 1'b1, SZ_W, 32'h20, 32'h1122_3344, 32'h0, 0, 0, acc);
        issue(1, 1'b1, SZ_B, 32'h22, 32'h0000_00AA, 32'h0, 0, 0, acc);
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 32'h11AA_3344, 0, 1, acc);
        issue(1, 1'b0, SZ_H, 32'h22, 32'h0, 32'h0000_11AA, 0, 1, acc);
        issue(1, 1'b0, SZ_B, 32'h23, 32'h0, 32'h0000_0011, 0, 1, acc);
        issue(1, 1'b0, SZ_H, 32'h23, 32'h0, 32'h0000_0011, 1, 1, acc);
        issue(1, 1'b0, 4'b0101, 32'h20, 32'h0, 32'h11AA_3344, 0, 1, acc);
        issue(1, 1'b1, SZ_H, 32'h21, 32'h0000_BEEF, 32'h0, 0, 0, acc);
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 32'h11BE_EF44, 0, 1, acc);
        issue(1, 1'b1, SZ_H, 32'h23, 32'h0000_1234, 32'h0, 1, 0, acc);
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 32'h34BE_EF44, 0, 1, acc);

        // Out of range: dropped store must not alias onto word 0
        issue(1, 1'b1, SZ_W, 32'h0, 32'h5566_7788, 32'h0, 0, 0, acc);
        issue(1, 1'b1, SZ_W, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1, 0, acc);
        issue(1, 1'b0, SZ_W, 32'h0, 32'h0, 32'h5566_7788, 0, 1, acc);
        issue(1, 1'b0, SZ_W, 32'h1000, 32'h0, 32'h0, 1, 1, acc);
        idle_bus();
        repeat (4) @(negedge clk);

        // Continuously valid load stream: each accept lands in the RESP cycle
        issue(1, 1'b0, SZ_W, 32'h0, 32'h0, 32'h5566_7788, 0, 1, acc_prev);
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 32'h34BE_EF44, 0, 1, acc);
        chk("b_stream_gap1", 32'(acc - acc_prev), 32'd3);
        acc_prev = acc;
        issue(1, 1'b0, SZ_H, 32'h22, 32'h0, 32'h0000_34BE, 0, 1, acc);
        chk("b_stream_gap2", 32'(acc - acc_prev), 32'd3);
        acc_prev = acc;
        issue(1, 1'b0, SZ_B, 32'h0, 32'h0, 32'h0000_0088, 0, 1, acc);
        chk("b_stream_gap3", 32'(acc - acc_prev), 32'd3);
        idle_bus();
        repeat (5) @(negedge clk);

        // Reset one cycle into a pending load: no response may follow
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 32'h0, 0, 0, acc);
        idle_bus();
        rstf_b = 1'b0;
        repeat (3) @(negedge clk);
        rstf_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("b_post_reset_ready", {31'b0, b_ready}, 32'd1);
        chk("b_post_reset_rvalid", {31'b0, b_rvalid}, 32'd0);
        chk("b_post_reset_rdata", b_rdata, 32'h0);
        chk("b_post_reset_err", {31'b0, b_err}, 32'd0);

        repeat (4) @(negedge clk);
        chk("a_rsp_queue_drained", 32'(a_q.size()), 32'd0);
        chk("b_rsp_queue_drained", 32'(b_q.size()), 32'd0);
        chk("a_err_queue_drained", 32'(a_eq.size()), 32'd0);
        chk("b_err_queue_drained", 32'(b_eq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the data bus driven by the memory-access stage. It accepts one `dbus_cmd_*` transaction at a time and performs byte-lane-masked stores into a local word-organised RAM. For loads it returns the addressed, zero-extended data on `dbus_rsp_*` after a fixed, parameterised latency. It sits between the memory-access stage and on-chip data storage, and also serves as the bench-side data memory for core simulation.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word aligned.
- `RSP_LATENCY`, 1: cycles from load acceptance to `dbus_rsp_valid`; range 1..15.
- `clk`, input, 1: sole clock, rising edge.
- `rstf`, input, 1: reset, asynchronous and active-low.
- `dbus_cmd_addr`, input, 32: byte address.
- `dbus_cmd_data`, input, 32: store data; bytes are right-justified (low lanes).
- `dbus_cmd_we`, input, 1: 1 = store, 0 = load.
- `dbus_cmd_size`, input, 4: access mask; 4'b0001 = byte, 4'b0011 = half, 4'b1111 = word.
- `dbus_cmd_valid`, input, 1: command present.
- `dbus_cmd_ready`, output, 1: command can be accepted this cycle.
- `dbus_rsp_data`, output, 32: load data, right-justified and zero-extended.
- `dbus_rsp_valid`, output, 1: single-cycle pulse; load data is valid.
- `dbus_err`, output, 1: single-cycle pulse on an out-of-range or word-crossing access.

## Operation
- **Accept:** a command is accepted when `valid & ready` is high at a rising edge.
- **Decode:**
  - off = `addr - BASE_ADDR`.
  - word index = off[log2(DEPTH_WORDS)+1:2].
  - lane = off[1:0].
  - In range iff `addr >= BASE_ADDR` and off < 4·DEPTH_WORDS.
- **Lane mask:** lane mask = (`size` << lane), truncated to 4 bits. If any mask bit is shifted out, the access crosses a word; it is still performed on the surviving lanes and `dbus_err` pulses.
- **Store:**
  - Write data is `cmd_data` << (8·lane).
  - Bytes are written under the lane mask at the accept edge.
  - No response is produced.
  - Out-of-range stores are dropped and `dbus_err` pulses.
- **Load:**
  - The word is read at the accept edge.
  - The returned data is (word >> 8·lane) & expand(`size`), where expand turns each mask bit into 8 bits.
  - An out-of-range load returns 32'h0 with `dbus_rsp_valid` and pulses `dbus_err`.
  - Sign extension is not done here; it belongs to writeback.
- **Sizes:** any `size` value other than 0001, 0011 or 1111 is treated as 1111.
- **Single outstanding access:** only one load is outstanding at a time.
- **FSM, 3 states:**
  - IDLE: `ready` = 1. Accepted store stays in IDLE. Accepted load goes to RESP if `RSP_LATENCY` = 1, otherwise to WAIT with cnt = `RSP_LATENCY` − 2.
  - WAIT: `ready` = 0. cnt decrements each cycle; at cnt = 0 go to RESP.
  - RESP: `dbus_rsp_valid` = 1 and `ready` = 1. A new command may be accepted in this same cycle and follows the IDLE transitions; otherwise go to IDLE.
- **Reset:** reset mid-transaction aborts any pending load; no response is issued after reset. RAM contents are not reset.

## Timing
- Reset values: `dbus_cmd_ready` = 1, `dbus_rsp_valid` = 0, `dbus_rsp_data` = 32'h0, `dbus_err` = 0, state = IDLE, cnt = 0.
- Load accepted at edge T: `dbus_rsp_valid` is high in the cycle after edge T+`RSP_LATENCY`−1, i.e. exactly `RSP_LATENCY` cycles after acceptance.
- `dbus_rsp_data` holds its last value when `dbus_rsp_valid` = 0.
- Store accepted at edge T: a load accepted at edge T+1 returns the new data (write-then-read ordering holds).
- `dbus_err` is registered and high in the cycle after the offending accept.
- Throughput:
  - Stores: 1 per cycle.
  - Loads: 1 per `RSP_LATENCY` cycles, using back-to-back acceptance in RESP.
- `dbus_cmd_ready` is a registered function of state only; it never depends combinationally on `dbus_cmd_valid`.

## Structure
- Shared package `riscv.svh`: add the mask constants `MEMSIZE_B` = 4'b0001, `MEMSIZE_H` = 4'b0011, `MEMSIZE_W` = 4'b1111, and the typedef `dmem_state_t` {IDLE, WAIT, RESP}.
- Sub-module `dmem_ram`: a single-port synchronous RAM, `DEPTH_WORDS` × 32, with 4 byte write enables and registered read data. It has no reset.
- The responder holds the decode, lane shifting, FSM, latency counter and error logic.

## Test plan
- **Word store/load:** store 32'hCAFEBABE at 0x10, then load word at 0x10 → `rsp_data` = 32'hCAFEBABE, `rsp_valid` 1 cycle after accept (`RSP_LATENCY` = 1).
- **Byte lanes:** with word 32'h11223344 at 0x20, store byte 32'hAA at 0x22 → word becomes 32'h11AA3344. Then:
  - Load half at 0x22 → 32'h000011AA.
  - Load byte at 0x23 → 32'h00000011.
- **Word crossing:** half load at 0x23 → returns byte lane 3 only, zero-extended, and `dbus_err` pulses once.
- **Out of range:** with `DEPTH_WORDS` = 1024, store to 0x1000 has no RAM change and `dbus_err` pulses. Load at 0x1000 → `rsp_data` = 0, `rsp_valid` = 1, `dbus_err` = 1.
- **Latency and back-to-back:** with `RSP_LATENCY` = 3, issue a continuously valid load stream:
  - `ready` is low for 2 cycles after each accept.
  - `rsp_valid` arrives 3 cycles after each accept.
  - The next load is accepted in each RESP cycle.
- **Reset mid-load:** with `RSP_LATENCY` = 3, deassert `rstf` 1 cycle after a load accept → no `rsp_valid` ever; after release `ready` = 1 and all outputs read 0.
